// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared defaults and FSM state codes for the SRAM arbiter.
// Optional starvation guard is enabled with SRAM_ARB_STARVE_GUARD_EN.
package sram_arb_pkg;

   localparam int ADDR_W_DEF       = 20;
   localparam int DATA_W_DEF       = 16;
   localparam int STARVE_LIMIT_DEF = 8;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t RD     = 3'd1;
   localparam state_t TURN   = 3'd2;
   localparam state_t WR     = 3'd3;
   localparam state_t WR_REL = 3'd4;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: read/write requester handshakes toward the SRAM arbiter.
// master = requester side, slave = arbiter side.
interface sram_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        wr_be;
   logic              wr_gnt;
   logic              wr_done;
   logic              busy;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
      input  rd_gnt, rd_valid, rd_data, wr_gnt, wr_done, busy
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
      output rd_gnt, rd_valid, rd_data, wr_gnt, wr_done, busy
   );

endinterface

// File: rtl/sram_phy.sv
// sram_phy: registered SRAM pin drivers, DQ tri-state and read-data capture.
// Strobes are decoded from the next state so pins change on the state edge.
module sram_phy
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  state_t            st,
   input  state_t            st_nxt,
   input  logic              ld_rd,
   input  logic              ld_wr,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [1:0]        wr_be,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N
);

   logic              dq_oe;
   logic [DATA_W-1:0] dq_q;

   assign SRAM_DQ = dq_oe ? dq_q : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         SRAM_ADDR <= '0;
         dq_q      <= '0;
         dq_oe     <= 1'b0;
         SRAM_CE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_WE_N <= 1'b1;
         SRAM_UB_N <= 1'b1;
         SRAM_LB_N <= 1'b1;
      end else begin
         rd_valid <= (st == RD);
         if (st == RD)
            rd_data <= SRAM_DQ;
         if (ld_rd)
            SRAM_ADDR <= rd_addr;
         else if (ld_wr)
            SRAM_ADDR <= wr_addr;
         if (ld_wr)
            dq_q <= wr_data;
         SRAM_CE_N <= (st_nxt == IDLE);
         SRAM_OE_N <= (st_nxt != RD);
         SRAM_WE_N <= (st_nxt != WR);
         dq_oe     <= (st_nxt == WR) || (st_nxt == WR_REL);
         // Byte strobes stay as written through WR_REL.
         if (st_nxt == RD) begin
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
         end else if (ld_wr) begin
            SRAM_UB_N <= ~wr_be[1];
            SRAM_LB_N <= ~wr_be[0];
         end else if (st_nxt != WR_REL) begin
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: read-priority arbiter for one async SRAM (display reads vs host writes).
// Define SRAM_ARB_STARVE_GUARD_EN to force a write after STARVE_LIMIT read grants.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   sram_arbiter_if.slave     bus,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N
);

   state_t st;
   state_t st_nxt;
   logic   go_rd;
   logic   go_wr;
   logic   pick_rd;
   logic   pick_wr;
   logic   force_wr;

`ifdef SRAM_ARB_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] starve_cnt;

   assign force_wr = (starve_cnt >= CW'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (!bus.wr_req || go_wr)
         starve_cnt <= '0;
      else if (go_rd && !force_wr)
         starve_cnt <= starve_cnt + CW'(1);
   end
`else
   localparam int unused_limit = STARVE_LIMIT;
   assign force_wr = 1'b0;
`endif

   always_comb begin
      pick_wr = bus.wr_req && (!bus.rd_req || force_wr);
      pick_rd = bus.rd_req && !pick_wr;
      st_nxt  = st;
      go_rd   = 1'b0;
      go_wr   = 1'b0;
      unique case (st)
         IDLE, RD, WR_REL: begin
            if (pick_rd) begin
               st_nxt = RD;
               go_rd  = 1'b1;
            end else if (pick_wr && st == RD) begin
               st_nxt = TURN;
            end else if (pick_wr) begin
               st_nxt = WR;
               go_wr  = 1'b1;
            end else begin
               st_nxt = IDLE;
            end
         end
         TURN: begin
            st_nxt = WR;
            go_wr  = 1'b1;
         end
         WR:      st_nxt = WR_REL;
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= IDLE;
         bus.rd_gnt  <= 1'b0;
         bus.wr_gnt  <= 1'b0;
         bus.wr_done <= 1'b0;
      end else begin
         st          <= st_nxt;
         bus.rd_gnt  <= go_rd;
         bus.wr_gnt  <= go_wr;
         bus.wr_done <= (st == WR);
      end
   end

   assign bus.busy = (st != IDLE);

   sram_phy #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_phy (
      .clk       (clk),
      .rst_n     (rst_n),
      .st        (st),
      .st_nxt    (st_nxt),
      .ld_rd     (go_rd),
      .ld_wr     (go_wr),
      .rd_addr   (bus.rd_addr),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .wr_be     (bus.wr_be),
      .rd_valid  (bus.rd_valid),
      .rd_data   (bus.rd_data),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ   (SRAM_DQ),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_UB_N (SRAM_UB_N),
      .SRAM_LB_N (SRAM_LB_N)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: SRAM model plus scoreboard of expected read data.
// Build with SRAM_ARB_STARVE_GUARD_EN to exercise the forced-write path.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   localparam int AW = 20;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   logic [AW-1:0] sram_addr;
   wire  [DW-1:0] sram_dq;
   logic          ce_n, oe_n, we_n, ub_n, lb_n;

   sram_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .SRAM_ADDR (sram_addr),
      .SRAM_DQ   (sram_dq),
      .SRAM_CE_N (ce_n),
      .SRAM_OE_N (oe_n),
      .SRAM_WE_N (we_n),
      .SRAM_UB_N (ub_n),
      .SRAM_LB_N (lb_n)
   );

   // async SRAM model; write commits at the end of a low-WE cycle
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] ref_mem [0:255];

   assign sram_dq = (!ce_n && !oe_n && we_n) ?
                    mem[sram_addr[7:0]] : {DW{1'bz}};

   always @(posedge clk) begin
      if (!ce_n && !we_n) begin
         if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
         if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      end
   end

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   logic [DW-1:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (bus.wr_done) done_cnt++;
      if (bus.rd_valid) begin
         if (exp_q.size() == 0) begin
            chk("rd_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rd_data", 32'(bus.rd_data), 32'(e));
         end
      end
   end

   task automatic ref_write(input logic [7:0] a, input logic [15:0] d,
                            input logic [1:0] be);
      if (be[1]) ref_mem[a][15:8] = d[15:8];
      if (be[0]) ref_mem[a][7:0]  = d[7:0];
   endtask

   task automatic do_read(input logic [7:0] a);
      bit ok = 0;
      bus.rd_req  = 1'b1;
      bus.rd_addr = AW'(a);
      exp_q.push_back(ref_mem[a]);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rd_gnt) begin ok = 1; break; end
      end
      bus.rd_req = 1'b0;
      chk("rd_gnt_seen", 32'(ok), 32'd1);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [15:0] d,
                           input logic [1:0] be);
      bit ok = 0;
      bus.wr_req  = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = d;
      bus.wr_be   = be;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.wr_gnt) begin ok = 1; break; end
      end
      bus.wr_req = 1'b0;
      chk("wr_gnt_seen", 32'(ok), 32'd1);
      if (ok) ref_write(a, d, be);
      @(negedge clk);
      chk("wr_done", 32'(bus.wr_done), 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!bus.busy && !bus.rd_valid && exp_q.size() == 0) break;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n_rg;
      int wg_at;
      int wg_cnt;
      int saved;
      bit ok;

      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'(i * 16'h0101);
         ref_mem[i] = 16'(i * 16'h0101);
      end
      mem[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;
      mem[8'h20] = 16'h0000; ref_mem[8'h20] = 16'h0000;
      mem[8'h30] = 16'hFFFF; ref_mem[8'h30] = 16'hFFFF;
      mem[8'h50] = 16'h7777; ref_mem[8'h50] = 16'h7777;
      bus.rd_req = 0; bus.rd_addr = '0;
      bus.wr_req = 0; bus.wr_addr = '0;
      bus.wr_data = '0; bus.wr_be = '0;

      #12;
      chk("rst_strobes", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1f);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dq_oe", 32'(dut.u_phy.dq_oe), 32'd0);
      chk("rst_flags", 32'({bus.rd_gnt, bus.rd_valid, bus.wr_gnt,
                            bus.wr_done, bus.busy}), 32'd0);
      chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // single read: gnt at k+1, valid at k+2, OE low one cycle
      bus.rd_req  = 1'b1;
      bus.rd_addr = AW'(8'h10);
      exp_q.push_back(ref_mem[8'h10]);
      @(negedge clk);
      chk("single_gnt", 32'(bus.rd_gnt), 32'd1);
      chk("single_oe_low", 32'(oe_n), 32'd0);
      bus.rd_req = 1'b0;
      @(negedge clk);
      chk("single_valid", 32'(bus.rd_valid), 32'd1);
      chk("single_oe_high", 32'(oe_n), 32'd1);
      wait_idle();

      // burst of four back-to-back reads
      bus.rd_req  = 1'b1;
      bus.rd_addr = '0;
      exp_q.push_back(ref_mem[0]);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("burst_gnt", 32'(bus.rd_gnt), 32'd1);
         if (i > 0) chk("burst_valid", 32'(bus.rd_valid), 32'd1);
         if (i < 3) begin
            bus.rd_addr = AW'(i + 1);
            exp_q.push_back(ref_mem[i + 1]);
         end else begin
            bus.rd_req = 1'b0;
         end
      end
      @(negedge clk);
      chk("burst_valid_last", 32'(bus.rd_valid), 32'd1);
      @(negedge clk);
      chk("burst_end", 32'(bus.rd_valid), 32'd0);
      wait_idle();

      // simultaneous request: read, TURN, WR, WR_REL
      bus.rd_req  = 1'b1;
      bus.rd_addr = AW'(8'h10);
      bus.wr_req  = 1'b1;
      bus.wr_addr = AW'(8'h20);
      bus.wr_data = 16'h1234;
      bus.wr_be   = 2'b11;
      exp_q.push_back(ref_mem[8'h10]);
      @(negedge clk);
      chk("sim_rd_first", 32'({bus.rd_gnt, bus.wr_gnt}), 32'b10);
      bus.rd_req = 1'b0;
      @(negedge clk);
      chk("sim_turn", 32'({ce_n, oe_n, we_n, bus.wr_gnt}), 32'b0110);
      chk("sim_turn_dq", 32'(dut.u_phy.dq_oe), 32'd0);
      @(negedge clk);
      chk("sim_wr_gnt", 32'({bus.wr_gnt, we_n, ub_n, lb_n}), 32'b1000);
      chk("sim_wr_dq", 32'(sram_dq), 32'h1234);
      bus.wr_req = 1'b0;
      ref_write(8'h20, 16'h1234, 2'b11);
      @(negedge clk);
      chk("sim_wr_done", 32'({bus.wr_done, we_n}), 32'b11);
      wait_idle();
      do_read(8'h20);
      wait_idle();

      // byte enables: lower byte only, then none
      do_write(8'h30, 16'hABCD, 2'b01);
      do_read(8'h30);
      wait_idle();
      do_write(8'h30, 16'h0000, 2'b00);
      do_read(8'h30);
      wait_idle();
      chk("be_ref", 32'(ref_mem[8'h30]), 32'hFFCD);

      // continuous reads with a pending write
      n_rg = 0; wg_at = -1; wg_cnt = 0;
      bus.rd_req  = 1'b1;
      bus.rd_addr = AW'(8'h10);
      bus.wr_req  = 1'b1;
      bus.wr_addr = AW'(8'h40);
      bus.wr_data = 16'h5555;
      bus.wr_be   = 2'b11;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.rd_gnt) begin
            exp_q.push_back(ref_mem[8'h10]);
            n_rg++;
         end
         if (bus.wr_gnt) begin
            wg_cnt++;
            if (wg_at < 0) wg_at = n_rg;
            bus.wr_req = 1'b0;
            ref_write(8'h40, 16'h5555, 2'b11);
         end
      end
      bus.rd_req = 1'b0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
      chk("starve_wgnt_after", 32'(wg_at), 32'd8);
`else
      chk("starve_no_wgnt", 32'(wg_cnt), 32'd0);
`endif
      if (bus.wr_req) begin
         ok = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.wr_gnt) begin ok = 1; break; end
         end
         bus.wr_req = 1'b0;
         chk("starve_late_wgnt", 32'(ok), 32'd1);
         if (ok) ref_write(8'h40, 16'h5555, 2'b11);
      end
      wait_idle();
      do_read(8'h40);
      wait_idle();

      // reset in the middle of a write
      saved = done_cnt;
      bus.wr_req  = 1'b1;
      bus.wr_addr = AW'(8'h50);
      bus.wr_data = 16'h0BAD;
      bus.wr_be   = 2'b11;
      @(negedge clk);
      chk("rst_wr_gnt", 32'({bus.wr_gnt, we_n}), 32'b10);
      rst_n = 1'b0;
      bus.wr_req = 1'b0;
      #1;
      chk("rst_we_high", 32'(we_n), 32'd1);
      chk("rst_dq_hiz", 32'(dut.u_phy.dq_oe), 32'd0);
      chk("rst_no_done_now", 32'(bus.wr_done), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_idle", 32'(bus.busy), 32'd0);
      chk("rst_no_done", 32'(done_cnt), 32'(saved));
      do_read(8'h50);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
